// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback pipe vs. buffered long-latency results.
// Long-latency results queue in a small FIFO, drain into idle cycles, and stall the pipe once the head has waited too long.
module core_wb_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_ready,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_wdata,
  output logic        ll_ready,
  output logic [31:0] ll_pending,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [4:0]    r_rd_mem   [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_wait;

  logic          w_empty;
  logic          w_full;
  logic          w_pipe_needs;
  logic          w_wait_sat;
  logic          w_force;
  logic          w_grant_fifo;
  logic          w_push;
  logic          w_store;
  logic          w_pop;
  logic [31:0]   w_pending;
  logic [AW-1:0] w_idx;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_pipe_needs = pipe_valid && (pipe_rd != 5'd0);
  assign w_wait_sat   = (r_wait >= WW'(MAX_WAIT));
  assign w_force      = !w_empty && w_wait_sat;
  assign w_grant_fifo = w_force || (!w_pipe_needs && !w_empty);

  // A push is refused on full even if the head pops in the same cycle; x0 pushes are swallowed.
  assign w_push  = rst && ll_valid && !w_full;
  assign w_store = w_push && (ll_rd != 5'd0);
  assign w_pop   = rst && w_grant_fifo;

  assign ll_ready   = rst && !w_full;
  assign pipe_ready = rst && !w_force;
  assign rf_wen     = rst && (w_grant_fifo || w_pipe_needs);
  assign rf_waddr   = w_grant_fifo ? r_rd_mem[r_rd_ptr]   : pipe_rd;
  assign rf_wdata   = w_grant_fifo ? r_data_mem[r_rd_ptr] : pipe_wdata;
  assign ll_pending = rst ? w_pending : 32'd0;

  // Destination mask over the occupied FIFO slots, for the issue scoreboard.
  always_comb begin
    w_pending = 32'd0;
    w_idx     = r_rd_ptr;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + AW'(i);
      if (CW'(i) < r_count) begin
        w_pending[r_rd_mem[w_idx]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_rd_mem[r_wr_ptr]   <= ll_rd;
      r_data_mem[r_wr_ptr] <= ll_wdata;
    end
  end

  // Pointers, occupancy and head-age counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wait   <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_store) - CW'(w_pop);
      if (w_empty || w_pop) begin
        r_wait <= '0;
      end else if (!w_wait_sat) begin
        r_wait <= r_wait + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Randomised and directed bench for core_wb_arbiter; a queue-based model predicts writes into a scoreboard.
module tb_core_wb_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        pipe_ready;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_wdata;
  logic        ll_ready;
  logic [31:0] ll_pending;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  core_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata), .pipe_ready(pipe_ready),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_wdata(ll_wdata), .ll_ready(ll_ready),
    .ll_pending(ll_pending),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  ent_t mq[$];
  int   age      = 0;
  wr_t  exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue of (rd,data), head age in cycles; predicts this cycle and the next state.
  always @(negedge clk) begin : model
    logic [31:0] pend;
    bit          pneeds, frc, gf, accept;
    wr_t         w;
    if (!rst) begin
      chk("rst_wen", 32'(rf_wen), 32'd0);
      chk("rst_pipe_ready", 32'(pipe_ready), 32'd0);
      chk("rst_ll_ready", 32'(ll_ready), 32'd0);
      chk("rst_pending", ll_pending, 32'd0);
      mq.delete();
      age = 0;
    end else begin
      pend = 32'd0;
      foreach (mq[i]) pend[mq[i].rd] = 1'b1;
      pneeds = pipe_valid && (pipe_rd != 5'd0);
      frc    = (mq.size() > 0) && (age >= MAX_WAIT);
      gf     = frc || (!pneeds && mq.size() > 0);
      accept = ll_valid && (mq.size() < DEPTH);
      chk("ll_ready", 32'(ll_ready), 32'(mq.size() < DEPTH));
      chk("pipe_ready", 32'(pipe_ready), 32'(!frc));
      chk("ll_pending", ll_pending, pend);
      if (gf) begin
        w.cyc = cyc; w.a = mq[0].rd; w.d = mq[0].data;
        exp_q.push_back(w);
      end else if (pneeds) begin
        w.cyc = cyc; w.a = pipe_rd; w.d = pipe_wdata;
        exp_q.push_back(w);
      end
      if (gf) begin
        void'(mq.pop_front());
        age = 0;
      end else if (mq.size() > 0) begin
        age = (age < MAX_WAIT) ? age + 1 : age;
      end else begin
        age = 0;
      end
      if (accept && ll_rd != 5'd0) mq.push_back({ll_rd, ll_wdata});
    end
  end

  // Monitor: every register-file write must match the next scoreboard entry, including its cycle.
  always @(negedge clk) begin : monitor
    wr_t e;
    #1;
    if (rst) begin
      if (rf_wen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%h want none", cyc, rf_waddr, rf_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(e.cyc));
          chk("wr_addr", 32'(rf_waddr), 32'(e.a));
          chk("wr_data", rf_wdata, e.d);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_err++;
        $display("FAIL missing_write cyc=%0d got none want addr=%0d data=%h", cyc, e.a, e.d);
      end
    end
  end

  task automatic drive(input bit r, input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    @(posedge clk);
    #1;
    rst = r; pipe_valid = pv; pipe_rd = prd; pipe_wdata = pd;
    ll_valid = lv; ll_rd = lrd; ll_wdata = ld;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b0; pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'h1111_0000;
    ll_valid = 1'b1; ll_rd = 5'd4; ll_wdata = 32'h2222_0000;
    // Reset with both requesters asserting.
    for (int i = 0; i < 3; i++) drive(0, 1, 5'd3, 32'h1111_0000 + 32'(i), 1, 5'd4, 32'h2222_0000 + 32'(i));
    // Idle drain.
    drive(1, 0, 5'd0, 32'd0, 1, 5'd5, 32'hDEAD_BEEF);
    idle(3);
    // Starvation: pipe writes x3 every cycle, one long-latency result for x7.
    drive(1, 1, 5'd3, 32'h3000_0000, 1, 5'd7, 32'h7777_7777);
    for (int i = 1; i < 14; i++) drive(1, 1, 5'd3, 32'h3000_0000 + 32'(i), 0, 5'd0, 32'd0);
    idle(2);
    // Full: fill while the pipe keeps the port busy.
    for (int i = 0; i < 20; i++)
      drive(1, 1, 5'd3, 32'h4000_0000 + 32'(i), (i < 7), 5'(10 + i), 32'hF000_0000 + 32'(i));
    idle(6);
    // x0 handling.
    drive(1, 1, 5'd3, 32'h5000_0000, 1, 5'd9, 32'h9999_9999);
    drive(1, 1, 5'd0, 32'h5000_0001, 0, 5'd0, 32'd0);
    drive(1, 0, 5'd0, 32'd0, 1, 5'd0, 32'hBAD0_BAD0);
    idle(3);
    // Wrap: back-to-back push/pop pairs.
    for (int i = 0; i < 3 * DEPTH; i++) drive(1, 0, 5'd0, 32'd0, 1, 5'(1 + i), 32'hA000_0000 + 32'(i));
    idle(3);
    // Mid-operation reset discards buffered entries.
    for (int i = 0; i < 4; i++) drive(1, 1, 5'd2, 32'(i), 1, 5'(20 + i), 32'(i));
    drive(0, 1, 5'd2, 32'd0, 1, 5'd6, 32'd0);
    idle(4);
    // Random traffic with varying pipe density and rare resets.
    for (int i = 0; i < 1500; i++) begin
      bit          r, pv, lv;
      logic [4:0]  prd, lrd;
      r   = ($urandom_range(0, 249) != 0);
      pv  = (i < 700) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      prd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lv  = ($urandom_range(0, 1) == 1);
      lrd = 5'($urandom_range(0, 7));
      drive(r, pv, prd, $urandom, lv, lrd, $urandom);
    end
    idle(30);
    @(negedge clk);
    #2;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
